// File: rtl/register_file_param.sv
// Parametrised register file: 2 async read ports, 1 sync write port, post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_param #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic w_wr_ok;
  logic w_rd_ok1;
  logic w_rd_ok2;
  logic w_hit1;
  logic w_hit2;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign w_wr_ok  = WE3 && !r_busy && f_in_range(A3) && !f_is_zero(A3);
  assign w_rd_ok1 = !r_busy && f_in_range(A1) && !f_is_zero(A1);
  assign w_rd_ok2 = !r_busy && f_in_range(A2) && !f_is_zero(A2);

`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = w_wr_ok && (A1 == A3);
  assign w_hit2 = w_wr_ok && (A2 == A3);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // Clear-sweep controller; any reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_ptr == LAST_IDX) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        S_IDLE:  r_state <= S_IDLE;
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Storage: the sweep owns the array while busy, so normal writes cannot collide with it.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_CLEAR)) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[A3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    if (w_rd_ok1) begin
      RD1 = w_hit1 ? WD3 : r_mem[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (w_rd_ok2) begin
      RD2 = w_hit2 ? WD3 : r_mem[A2];
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: a 16-entry and a 12-entry instance share stimulus.
// Expected values are hand-computed; REGFILE_BYPASS_EN selects the forwarding expectations.
module tb_register_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        WE3;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [3:0]  A3;
  logic [23:0] WD3;
  logic [23:0] rd1_16, rd2_16, rd1_12, rd2_12;
  logic        busy_16, busy_12;

  register_file_param #(.DATA_W(24), .NUM_REGS(16), .ZERO_REG(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(rd1_16), .RD2(rd2_16), .busy(busy_16)
  );

  register_file_param #(.DATA_W(24), .NUM_REGS(12), .ZERO_REG(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(rd1_12), .RD2(rd2_12), .busy(busy_12)
  );

  typedef struct {
    bit          sel12;
    logic [23:0] e1;
    logic [23:0] e2;
    logic        eb;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit sel12, input string nm, input logic [23:0] e1,
                     input logic [23:0] e2, input logic eb);
    exp_t e;
    e.sel12 = sel12;
    e.e1    = e1;
    e.e2    = e2;
    e.eb    = eb;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare everything queued this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      string       nm;
      logic [23:0] g1, g2;
      logic        gb;
      e  = q.pop_front();
      nm = qn.pop_front();
      g1 = e.sel12 ? rd1_12  : rd1_16;
      g2 = e.sel12 ? rd2_12  : rd2_16;
      gb = e.sel12 ? busy_12 : busy_16;
      n_checks++;
      if (g1 !== e.e1 || g2 !== e.e2 || gb !== e.eb)
        $display("FAIL %s dut%0d: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                 nm, e.sel12 ? 12 : 16, g1, g2, gb, e.e1, e.e2, e.eb);
      else
        n_pass++;
    end
  end

  initial begin
    rst = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

    // T1: reset then sweep
    cyc(); cyc();
    chk(0, "reset_state", 24'h0, 24'h0, 1'b1);
    chk(1, "reset_state", 24'h0, 24'h0, 1'b1);
    rst = 1'b0;
    A1 = 4'd5; A2 = 4'd3;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      WE3 = (k == 1);               // T5: write during busy must be dropped
      A3  = 4'd3;
      WD3 = 24'h55AA55;
      if (k >= 16) begin A1 = 4'd0; A2 = 4'd0; end
      chk(0, "sweep_busy16", 24'h0, 24'h0, (k < 16));
      if (k == 11 || k == 12) chk(1, "sweep_busy12", 24'h0, 24'h0, (k < 12));
    end
    WE3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      A1 = 4'(i); A2 = 4'(15 - i);
      chk(0, "post_sweep_zero16", 24'h0, 24'h0, 1'b0);
      chk(1, "post_sweep_zero12", 24'h0, 24'h0, 1'b0);
      cyc();
    end

    // T2: basic write/read
    WE3 = 1'b1; A3 = 4'd5; WD3 = 24'hABCDEF; A1 = 4'd5; A2 = 4'd5;
    chk(0, "wr5_same_cycle", BYP ? 24'hABCDEF : 24'h0, BYP ? 24'hABCDEF : 24'h0, 1'b0);
    chk(1, "wr5_same_cycle", BYP ? 24'hABCDEF : 24'h0, BYP ? 24'hABCDEF : 24'h0, 1'b0);
    cyc();
    WE3 = 1'b0;
    chk(0, "rd5", 24'hABCDEF, 24'hABCDEF, 1'b0);
    chk(1, "rd5", 24'hABCDEF, 24'hABCDEF, 1'b0);
    cyc();

    // T3: R0 and out-of-range
    WE3 = 1'b1; A3 = 4'd0; WD3 = 24'h123456; A1 = 4'd0; A2 = 4'd5;
    chk(0, "wr_r0_same_cycle", 24'h0, 24'hABCDEF, 1'b0);
    cyc();
    WE3 = 1'b0;
    chk(0, "rd_r0", 24'h0, 24'hABCDEF, 1'b0);
    chk(1, "rd_r0", 24'h0, 24'hABCDEF, 1'b0);
    cyc();
    WE3 = 1'b1; A3 = 4'd13; WD3 = 24'h777777; A1 = 4'd13; A2 = 4'd5;
    chk(1, "wr_oor_same_cycle", 24'h0, 24'hABCDEF, 1'b0);
    chk(0, "wr13_same_cycle", BYP ? 24'h777777 : 24'h0, 24'hABCDEF, 1'b0);
    cyc();
    WE3 = 1'b0;
    chk(1, "rd_oor13", 24'h0, 24'hABCDEF, 1'b0);
    chk(0, "rd13", 24'h777777, 24'hABCDEF, 1'b0);
    cyc();
    A1 = 4'd1; A2 = 4'd12;
    chk(1, "oor_no_alias", 24'h0, 24'h0, 1'b0);
    cyc();
    WE3 = 1'b1; A3 = 4'd11; WD3 = 24'h0000BB; A1 = 4'd0; A2 = 4'd0;
    cyc();
    WE3 = 1'b0; A1 = 4'd11; A2 = 4'd12;
    chk(1, "rd_last_and_first_oor", 24'h0000BB, 24'h0, 1'b0);
    chk(0, "rd11_rd12", 24'h0000BB, 24'h0, 1'b0);
    cyc();

    // T4: bypass behaviour
    WE3 = 1'b1; A3 = 4'd7; WD3 = 24'h000011;
    cyc();
    A3 = 4'd7; WD3 = 24'h0000FF; A1 = 4'd7; A2 = 4'd5;
    chk(0, "bypass_r7", BYP ? 24'h0000FF : 24'h000011, 24'hABCDEF, 1'b0);
    cyc();
    WE3 = 1'b0;
    chk(0, "r7_after_write", 24'h0000FF, 24'hABCDEF, 1'b0);
    cyc();

    // T6: reset mid-sweep
    WE3 = 1'b1; A3 = 4'd9; WD3 = 24'h000009;
    cyc();
    WE3 = 1'b0; A1 = 4'd9; A2 = 4'd7;
    chk(0, "rd9", 24'h000009, 24'h0000FF, 1'b0);
    rst = 1'b1;
    cyc();
    chk(0, "rst_from_idle", 24'h0, 24'h0, 1'b1);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk(0, "partial_sweep_busy", 24'h0, 24'h0, 1'b1);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk(0, "resweep_busy16", 24'h0, 24'h0, (k < 16));
      if (k == 11 || k == 12) chk(1, "resweep_busy12", 24'h0, 24'h0, (k < 12));
    end
    A1 = 4'd13; A2 = 4'd5;
    chk(0, "resweep_cleared", 24'h0, 24'h0, 1'b0);
    chk(1, "resweep_cleared", 24'h0, 24'h0, 1'b0);
    cyc();
    cyc();

    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
